// File: rtl/ps2_mouse_pkg.sv
// Shared types and byte constants for the PS/2 mouse bring-up sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ps2_mouse_pkg;

    typedef enum logic [3:0] {
        RST_SEND = 4'd0,
        RST_ACK  = 4'd1,
        WAIT_BAT = 4'd2,
        WAIT_ID  = 4'd3,
        EN_SEND  = 4'd4,
        EN_ACK   = 4'd5,
        PKT0     = 4'd6,
        PKT1     = 4'd7,
        PKT2     = 4'd8,
        FAIL     = 4'd9
    } ps2_state_e;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    localparam int WDT_W = 24;

    // True while streaming packets (drives the ready flag).
    function automatic logic is_pkt_state(input ps2_state_e s);
        return (s == PKT0) || (s == PKT1) || (s == PKT2);
    endfunction

endpackage

// File: rtl/ps2_watchdog_timer.sv
// Loadable 24-bit down-counter; flags expiry when it reads zero while armed.
// Latency: load takes effect on the next cycle; expired is a function of the flops.
// Backpressure: none; load has priority over disarm, counter parks at zero.
//
// Ports: clk, rst_n (async active-low), load + load_val arm and preset the
// counter, disarm stops it, expired is high while armed and at zero.
module ps2_watchdog_timer
    import ps2_mouse_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WDT_W-1:0] load_val,
    input  logic             disarm,
    output logic             expired
);

    logic [WDT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load) begin
            cnt_d   = load_val;
            armed_d = 1'b1;
        end else if (disarm) begin
            armed_d = 1'b0;
        end else if (armed_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign expired = armed_q && (cnt_q == '0);

endmodule

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up (reset, BAT, ID, enable) then 3-byte packet assembly.
// Latency: all outputs registered; packet outputs 1 cycle after the third byte.
// Backpressure: none; holds cmd_send until the transceiver reports sent/timeout.
//
// Ports: CLOCK_50/resetn clock and async active-low reset; reinit restarts
// bring-up; rx_data/rx_valid, cmd_sent, cmd_timeout come from the transceiver;
// cmd_byte/cmd_send drive it; ready, init_error report bring-up status;
// mouse_dx/dy/btn/ovf with packet_valid carry each decoded packet.
module ps2_mouse_sequencer
    import ps2_mouse_pkg::*;
#(
    parameter logic [23:0] ACK_TIMEOUT = 24'd5_000_000,
    parameter logic [23:0] BYTE_GAP    = 24'd100_000,
    parameter int          MAX_RETRIES = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       reinit,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cmd_sent,
    input  logic       cmd_timeout,
    output logic [7:0] cmd_byte,
    output logic       cmd_send,
    output logic       ready,
    output logic       init_error,
    output logic [8:0] mouse_dx,
    output logic [8:0] mouse_dy,
    output logic [2:0] mouse_btn,
    output logic [1:0] mouse_ovf,
    output logic       packet_valid
);

    localparam logic [3:0] MAX_RETRY_LIM = 4'(MAX_RETRIES);

    ps2_state_e  state_q, state_d;
    logic [2:0]  retry_q, retry_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        cmd_send_q, cmd_send_d;
    logic        ready_q, ready_d;
    logic        init_error_q, init_error_d;
    // Header byte minus the always-one sync bit: {ovf[1:0], sy, sx, btn[2:0]}.
    logic [6:0]  hdr_q, hdr_d;
    logic [7:0]  b1_q, b1_d;
    logic [8:0]  dx_q, dx_d, dy_q, dy_d;
    logic [2:0]  btn_q, btn_d;
    logic [1:0]  ovf_q, ovf_d;
    logic        pv_q, pv_d;

    logic        wd_load, wd_disarm, wd_expired;
    logic [23:0] wd_val;
    logic        retry_evt, retry_exhausted;
    ps2_state_e  retry_tgt;

    assign retry_exhausted = ({1'b0, retry_q} + 4'd1) > MAX_RETRY_LIM;

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        cmd_send_d = 1'b0;
        cmd_byte_d = cmd_byte_q;
        hdr_d      = hdr_q;
        b1_d       = b1_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        btn_d      = btn_q;
        ovf_d      = ovf_q;
        pv_d       = 1'b0;
        wd_load    = 1'b0;
        wd_disarm  = 1'b0;
        wd_val     = ACK_TIMEOUT;
        retry_evt  = 1'b0;
        // Failures before the enable command restart the whole reset handshake.
        retry_tgt  = ((state_q == EN_SEND) || (state_q == EN_ACK)) ? EN_SEND : RST_SEND;

        case (state_q)
            RST_SEND, EN_SEND: begin
                if (cmd_sent) begin
                    state_d = (state_q == RST_SEND) ? RST_ACK : EN_ACK;
                    wd_load = 1'b1;
                end else if (cmd_timeout) begin
                    retry_evt = 1'b1;
                end else begin
                    // Low on the entry cycle so every (re)send starts with a rising edge.
                    cmd_send_d = 1'b1;
                end
            end
            RST_ACK, WAIT_BAT, WAIT_ID, EN_ACK: begin
                if (rx_valid) begin
                    case (state_q)
                        RST_ACK: begin
                            if (rx_data == RSP_ACK) begin
                                state_d = WAIT_BAT;
                                wd_load = 1'b1;
                            end else retry_evt = 1'b1;
                        end
                        WAIT_BAT: begin
                            if (rx_data == RSP_BAT_OK) begin
                                state_d = WAIT_ID;
                                wd_load = 1'b1;
                            end else retry_evt = 1'b1;
                        end
                        WAIT_ID: begin
                            if (rx_data == RSP_ID) begin
                                state_d   = EN_SEND;
                                retry_d   = 3'd0;
                                wd_disarm = 1'b1;
                            end else retry_evt = 1'b1;
                        end
                        default: begin
                            if (rx_data == RSP_ACK) begin
                                state_d   = PKT0;
                                wd_disarm = 1'b1;
                            end else retry_evt = 1'b1;
                        end
                    endcase
                end else if (wd_expired) begin
                    retry_evt = 1'b1;
                end
            end
            PKT0: begin
                // Bit 3 of a header is always set; anything else is a stray byte.
                if (rx_valid && rx_data[3]) begin
                    hdr_d   = {rx_data[7:4], rx_data[2:0]};
                    state_d = PKT1;
                    wd_load = 1'b1;
                    wd_val  = BYTE_GAP;
                end
            end
            PKT1: begin
                if (rx_valid) begin
                    b1_d    = rx_data;
                    state_d = PKT2;
                    wd_load = 1'b1;
                    wd_val  = BYTE_GAP;
                end else if (wd_expired) begin
                    state_d   = PKT0;
                    wd_disarm = 1'b1;
                end
            end
            PKT2: begin
                if (rx_valid) begin
                    dx_d      = {hdr_q[3], b1_q};
                    dy_d      = {hdr_q[4], rx_data};
                    btn_d     = hdr_q[2:0];
                    ovf_d     = hdr_q[6:5];
                    pv_d      = 1'b1;
                    state_d   = PKT0;
                    wd_disarm = 1'b1;
                end else if (wd_expired) begin
                    state_d   = PKT0;
                    wd_disarm = 1'b1;
                end
            end
            FAIL: begin
                wd_disarm = 1'b1;
            end
            default: begin
                state_d = RST_SEND;
                retry_d = 3'd0;
            end
        endcase

        if (retry_evt) begin
            wd_disarm = 1'b1;
            if (retry_exhausted) begin
                state_d = FAIL;
            end else begin
                state_d = retry_tgt;
                retry_d = retry_q + 3'd1;
            end
        end

        if (reinit) begin
            state_d    = RST_SEND;
            retry_d    = 3'd0;
            cmd_send_d = 1'b0;
            wd_load    = 1'b0;
            wd_disarm  = 1'b1;
        end

        if (state_d == RST_SEND)     cmd_byte_d = CMD_RESET;
        else if (state_d == EN_SEND) cmd_byte_d = CMD_ENABLE;

        ready_d      = is_pkt_state(state_d);
        init_error_d = (state_d == FAIL);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RST_SEND;
            retry_q      <= 3'd0;
            cmd_byte_q   <= 8'h00;
            cmd_send_q   <= 1'b0;
            ready_q      <= 1'b0;
            init_error_q <= 1'b0;
            hdr_q        <= '0;
            b1_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            btn_q        <= '0;
            ovf_q        <= '0;
            pv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_send_q   <= cmd_send_d;
            ready_q      <= ready_d;
            init_error_q <= init_error_d;
            hdr_q        <= hdr_d;
            b1_q         <= b1_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            btn_q        <= btn_d;
            ovf_q        <= ovf_d;
            pv_q         <= pv_d;
        end
    end

    ps2_watchdog_timer u_wdt (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .load     (wd_load),
        .load_val (wd_val),
        .disarm   (wd_disarm),
        .expired  (wd_expired)
    );

    assign cmd_byte     = cmd_byte_q;
    assign cmd_send     = cmd_send_q;
    assign ready        = ready_q;
    assign init_error   = init_error_q;
    assign mouse_dx     = dx_q;
    assign mouse_dy     = dy_q;
    assign mouse_btn    = btn_q;
    assign mouse_ovf    = ovf_q;
    assign packet_valid = pv_q;

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Bench for ps2_mouse_sequencer: transceiver/mouse model with random faults and packets.
// Latency: expects packet outputs one cycle after the third packet byte.
// Backpressure: model answers cmd_send after a short random delay.
module tb_ps2_mouse_sequencer;

    localparam int ACK_TO = 300;
    localparam int GAP    = 200;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       reinit = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cmd_sent = 1'b0;
    logic       cmd_timeout = 1'b0;
    logic [7:0] cmd_byte;
    logic       cmd_send, ready, init_error, packet_valid;
    logic [8:0] mouse_dx, mouse_dy;
    logic [2:0] mouse_btn;
    logic [1:0] mouse_ovf;

    always #5 clk = ~clk;

    ps2_mouse_sequencer #(
        .ACK_TIMEOUT (24'd300),
        .BYTE_GAP    (24'd200),
        .MAX_RETRIES (2)
    ) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .reinit       (reinit),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cmd_sent     (cmd_sent),
        .cmd_timeout  (cmd_timeout),
        .cmd_byte     (cmd_byte),
        .cmd_send     (cmd_send),
        .ready        (ready),
        .init_error   (init_error),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .mouse_btn    (mouse_btn),
        .mouse_ovf    (mouse_ovf),
        .packet_valid (packet_valid)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int dx;
        int dy;
        int btn;
        int ovf;
    } pkt_t;

    pkt_t exp_q[$];
    int   pkts_seen = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Movement is a 9-bit two's-complement number whose sign lives in the header.
    function automatic pkt_t ref_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2);
        pkt_t p;
        p.dx  = int'(b1) - (b0[4] ? 256 : 0);
        p.dy  = int'(b2) - (b0[5] ? 256 : 0);
        p.btn = int'(b0) % 8;
        p.ovf = int'(b0) / 64;
        return p;
    endfunction

    always @(negedge clk) begin
        pkt_t e;
        if (resetn && packet_valid) begin
            pkts_seen++;
            if (exp_q.size() == 0) begin
                check_eq("pkt_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pkt_dx",  int'($signed(mouse_dx)), e.dx);
                check_eq("pkt_dy",  int'($signed(mouse_dy)), e.dy);
                check_eq("pkt_btn", int'(mouse_btn), e.btn);
                check_eq("pkt_ovf", int'(mouse_ovf), e.ovf);
            end
        end
    end

    // All stimulus changes happen on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < ACK_TO + 100; i++) begin
            if (cmd_send) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check_eq("cmd_wait_timeout", 0, 1);
    endtask

    task automatic pulse_sent();
        cmd_sent = 1'b1;
        @(negedge clk);
        cmd_sent = 1'b0;
        check_eq("send_drop", int'(cmd_send), 0);
    endtask

    task automatic pulse_timeout();
        cmd_timeout = 1'b1;
        @(negedge clk);
        cmd_timeout = 1'b0;
        check_eq("send_drop_to", int'(cmd_send), 0);
    endtask

    // Each injected fault costs exactly one more attempt of the same command.
    task automatic bringup(input int n_rst, input int n_en);
        bit ok;
        for (int a = 0; a <= n_rst; a++) begin
            wait_cmd(ok);
            if (!ok) return;
            check_eq("rst_cmd", int'(cmd_byte), 8'hFF);
            check_eq("ready_low", int'(ready), 0);
            if (a < n_rst) begin
                int f = int'($urandom_range(0, 3));
                case (f)
                    0: pulse_timeout();
                    1: begin pulse_sent(); send_byte(8'hFE); end
                    2: begin pulse_sent(); send_byte(8'hFA); tick(1); send_byte(8'hAB); end
                    default: pulse_sent();
                endcase
            end else begin
                pulse_sent();
                tick(int'($urandom_range(0, 3)));
                send_byte(8'hFA);
                tick(1);
                send_byte(8'hAA);
                tick(1);
                send_byte(8'h00);
            end
        end
        for (int a = 0; a <= n_en; a++) begin
            wait_cmd(ok);
            if (!ok) return;
            check_eq("en_cmd", int'(cmd_byte), 8'hF4);
            if (a < n_en) begin
                int f = int'($urandom_range(0, 2));
                case (f)
                    0: pulse_timeout();
                    1: begin pulse_sent(); send_byte(8'h55); end
                    default: pulse_sent();
                endcase
            end else begin
                pulse_sent();
                tick(int'($urandom_range(0, 3)));
                send_byte(8'hFA);
            end
        end
        check_eq("ready_up", int'(ready), 1);
        check_eq("no_init_err", int'(init_error), 0);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int gap);
        exp_q.push_back(ref_pkt(b0, b1, b2));
        send_byte(b0);
        tick(gap);
        send_byte(b1);
        tick(gap);
        send_byte(b2);
        check_eq("pv_latency", int'(packet_valid), 1);
        tick(1);
        check_eq("pv_pulse", int'(packet_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_byte"}, int'(cmd_byte), 0);
        check_eq({tag, "_cmd_send"}, int'(cmd_send), 0);
        check_eq({tag, "_ready"}, int'(ready), 0);
        check_eq({tag, "_init_err"}, int'(init_error), 0);
        check_eq({tag, "_dx"}, int'(mouse_dx), 0);
        check_eq({tag, "_dy"}, int'(mouse_dy), 0);
        check_eq({tag, "_btn"}, int'(mouse_btn), 0);
        check_eq({tag, "_ovf"}, int'(mouse_ovf), 0);
        check_eq({tag, "_pv"}, int'(packet_valid), 0);
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL global_timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bit         ok;
        bit         seen;
        int         base;
        int         last_dx;
        logic [7:0] b0, junk;

        tick(3);
        check_reset_outputs("rst");
        resetn = 1'b1;

        // Mouse never answers: three reset attempts, then give up.
        for (int a = 0; a < 3; a++) begin
            wait_cmd(ok);
            if (ok) begin
                check_eq("fail_cmd", int'(cmd_byte), 8'hFF);
                pulse_sent();
            end
        end
        for (int i = 0; i < ACK_TO + 100; i++) begin
            if (init_error) break;
            tick(1);
        end
        check_eq("fail_init_err", int'(init_error), 1);
        check_eq("fail_cmd_send", int'(cmd_send), 0);
        check_eq("fail_ready", int'(ready), 0);
        seen = 1'b0;
        repeat (ACK_TO + 50) begin
            tick(1);
            if (cmd_send) seen = 1'b1;
        end
        check_eq("fail_quiet", int'(seen), 0);

        reinit = 1'b1;
        tick(1);
        reinit = 1'b0;
        check_eq("reinit_clr", int'(init_error), 0);
        bringup(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        send_pkt(8'h19, 8'hFE, 8'h05, 0);
        check_eq("dir_dx", int'($signed(mouse_dx)), -2);
        check_eq("dir_dy", int'($signed(mouse_dy)), 5);
        check_eq("dir_btn", int'(mouse_btn), 1);

        // A header without the sync bit is dropped.
        send_byte(8'h00);
        tick(1);
        send_pkt(8'h08, 8'h01, 8'h02, 1);
        check_eq("desync_dx", int'($signed(mouse_dx)), 1);
        check_eq("desync_dy", int'($signed(mouse_dy)), 2);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom) & 8'hF7;
                send_byte(junk);
                tick(1);
            end
            b0 = 8'($urandom) | 8'h08;
            send_pkt(b0, 8'($urandom), 8'($urandom),
                     (i == 20) ? GAP - 10 : int'($urandom_range(0, 3)));
        end
        last_dx = int'($signed(mouse_dx));
        tick(10);
        check_eq("hold_dx", int'($signed(mouse_dx)), last_dx);

        // Partial packet abandoned after the inter-byte gap runs out.
        base = pkts_seen;
        send_byte(8'h08);
        tick(1);
        send_byte(8'h01);
        tick(GAP + 10);
        send_pkt(8'h08, 8'h03, 8'h04, 1);
        check_eq("gap_count", pkts_seen - base, 1);
        check_eq("gap_dx", int'($signed(mouse_dx)), 3);
        check_eq("gap_dy", int'($signed(mouse_dy)), 4);

        // Asynchronous reset in the middle of a packet.
        send_pkt(8'hFF, 8'h80, 8'h7F, 0);
        send_byte(8'h08);
        tick(1);
        send_byte(8'h01);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("arst");
        tick(2);
        resetn = 1'b1;
        bringup(0, 0);
        send_pkt(8'($urandom) | 8'h08, 8'($urandom), 8'($urandom), 2);

        tick(5);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
